// File: rtl/sopc_run_pkg.sv
// Shared types and default constants for the SOPC run controller.
// The end-cause priority lives here so the top and any future status block agree on it.
package sopc_run_pkg;

   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } run_state_e;

   typedef enum logic [2:0] {
      END_NONE,
      END_PASS,
      END_FAIL,
      END_HALT,
      END_TIMEOUT
   } end_cause_e;

   localparam logic [31:0] DEF_PASS_CODE = 32'h0000_600D;
   localparam logic [31:0] DEF_MBOX_ADDR = 32'h0000_1000;

   // Mailbox beats a stall halt, which beats the watchdog.
   function automatic end_cause_e pick_end_cause(
      input logic mbox_hit,
      input logic is_pass,
      input logic stall_halt,
      input logic watchdog
   );
      if (mbox_hit)        return is_pass ? END_PASS : END_FAIL;
      else if (stall_halt) return END_HALT;
      else if (watchdog)   return END_TIMEOUT;
      return END_NONE;
   endfunction

endpackage

// File: rtl/run_stall_det.sv
// PC-stall detector: flags a halt once the fetch PC has been unchanged for STALL_LIMIT
// consecutive enabled cycles. STALL_LIMIT of 0 disables detection entirely.
module run_stall_det #(
   parameter int STALL_LIMIT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        clr,
   input  logic [31:0] pc,
   output logic        halt
);

   localparam int SC_W = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;
   // The pulse fires on the comparison that would bring the count to STALL_LIMIT-1.
   localparam logic [SC_W-1:0] HALT_AT = SC_W'((STALL_LIMIT >= 2) ? STALL_LIMIT - 2 : 0);

   logic [31:0]     prev_pc;
   logic            prev_valid;
   logic [SC_W-1:0] same_cnt;
   logic            same;

   // No comparison until prev_pc holds a sample from this run.
   assign same = prev_valid && (pc == prev_pc);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         prev_pc    <= '0;
         prev_valid <= 1'b0;
         same_cnt   <= '0;
      end else if (en) begin
         prev_pc    <= pc;
         prev_valid <= 1'b1;
         same_cnt   <= same ? same_cnt + 1'b1 : '0;
      end
   end

   assign halt = (STALL_LIMIT != 0) && en && same && (same_cnt == HALT_AT);

endmodule

// File: rtl/sopc_run_ctrl.sv
// Run controller for the SOPC core: timed reset release, run-cycle counting and
// end-of-run detection via mailbox write, PC-stall halt or watchdog timeout.
module sopc_run_ctrl
   import sopc_run_pkg::*;
#(
   parameter int          CNT_W       = 23,
   parameter int          RST_HOLD    = 10,
   parameter int          MAX_CYCLES  = 50,
   parameter int          STALL_LIMIT = 8,
   parameter logic [31:0] MBOX_ADDR   = DEF_MBOX_ADDR,
   parameter logic [31:0] PASS_CODE   = DEF_PASS_CODE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      pc_i,
   input  logic             mem_we_i,
   input  logic [31:0]      mem_addr_i,
   input  logic [31:0]      mem_data_i,
   output logic             core_rst_o,
   output logic             running_o,
   output logic             done_o,
   output logic             pass_o,
   output logic             fail_o,
   output logic             halt_o,
   output logic             timeout_o,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic [31:0]      mailbox_o
);

   localparam int                HOLD_W     = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RST_HOLD - 1);
   localparam logic [CNT_W-1:0]  CYCLE_LAST = CNT_W'(MAX_CYCLES - 1);

   run_state_e        state;
   logic [HOLD_W-1:0] hold_cnt;
   logic              in_run;
   logic              mbox_hit;
   logic              stall_halt;
   end_cause_e        cause;

   assign in_run   = (state == ST_RUN);
   assign mbox_hit = mem_we_i && (mem_addr_i == MBOX_ADDR);
   assign cause    = pick_end_cause(mbox_hit, mem_data_i == PASS_CODE, stall_halt,
                                    cycle_cnt_o == CYCLE_LAST);

   run_stall_det #(
      .STALL_LIMIT(STALL_LIMIT)
   ) u_stall (
      .clk   (clk),
      .reset (reset),
      .en    (in_run),
      .clr   (!in_run),
      .pc    (pc_i),
      .halt  (stall_halt)
   );

   // NOTE: reset is synchronous, so it sits inside the clocked block and every
   // register, mailbox included, gets a known value; all state uses <= only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_HOLD;
         hold_cnt    <= '0;
         core_rst_o  <= 1'b1;
         running_o   <= 1'b0;
         done_o      <= 1'b0;
         pass_o      <= 1'b0;
         fail_o      <= 1'b0;
         halt_o      <= 1'b0;
         timeout_o   <= 1'b0;
         cycle_cnt_o <= '0;
         mailbox_o   <= '0;
      end else begin
         unique case (state)
            ST_HOLD: begin
               if (hold_cnt == HOLD_LAST) begin
                  state      <= ST_RUN;
                  core_rst_o <= 1'b0;
                  running_o  <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               if (cause == END_NONE) begin
                  cycle_cnt_o <= cycle_cnt_o + 1'b1;
               end else begin
                  // Counter freezes on the terminating cycle; the core is put back in reset.
                  state      <= ST_DONE;
                  running_o  <= 1'b0;
                  done_o     <= 1'b1;
                  core_rst_o <= 1'b1;
                  pass_o     <= (cause == END_PASS);
                  fail_o     <= (cause == END_FAIL);
                  halt_o     <= (cause == END_HALT);
                  timeout_o  <= (cause == END_TIMEOUT);
                  if (mbox_hit) mailbox_o <= mem_data_i;
               end
            end
            ST_DONE: ;
            default: state <= ST_HOLD;
         endcase
      end
   end

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Directed bench for sopc_run_ctrl; a second instance with stall detection disabled
// shares the stimulus for the watchdog-fallback case.
module tb_sopc_run_ctrl;

   logic        clk      = 1'b0;
   logic        reset    = 1'b1;
   logic [31:0] pc       = '0;
   logic        mem_we   = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_data = '0;

   logic        core_rst, running, done, pass, fail, halt, timeout;
   logic [22:0] cycle_cnt;
   logic [31:0] mailbox;
   logic        ns_core_rst, ns_running, ns_done, ns_pass, ns_fail, ns_halt, ns_timeout;
   logic [22:0] ns_cycle_cnt;
   logic [31:0] ns_mailbox;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sopc_run_ctrl dut (
      .clk(clk), .reset(reset), .pc_i(pc), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
      .mem_data_i(mem_data), .core_rst_o(core_rst), .running_o(running), .done_o(done),
      .pass_o(pass), .fail_o(fail), .halt_o(halt), .timeout_o(timeout),
      .cycle_cnt_o(cycle_cnt), .mailbox_o(mailbox)
   );

   sopc_run_ctrl #(.STALL_LIMIT(0)) dut_ns (
      .clk(clk), .reset(reset), .pc_i(pc), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
      .mem_data_i(mem_data), .core_rst_o(ns_core_rst), .running_o(ns_running), .done_o(ns_done),
      .pass_o(ns_pass), .fail_o(ns_fail), .halt_o(ns_halt), .timeout_o(ns_timeout),
      .cycle_cnt_o(ns_cycle_cnt), .mailbox_o(ns_mailbox)
   );

   // Observed status as {core_rst, running, done, pass, fail, halt, timeout}.
   function automatic logic [6:0] st();
      return {core_rst, running, done, pass, fail, halt, timeout};
   endfunction

   function automatic logic [6:0] ns_st();
      return {ns_core_rst, ns_running, ns_done, ns_pass, ns_fail, ns_halt, ns_timeout};
   endfunction

   function automatic logic [31:0] pc_of(input int c);
      return 32'h0000_0100 + 32'(4 * c);
   endfunction

   // Inputs are driven at the negedge for the cycle that follows, then one cycle elapses.
   task automatic run_cycle(input logic [31:0] p, input logic we, input logic [31:0] addr,
                            input logic [31:0] data);
      pc       = p;
      mem_we   = we;
      mem_addr = addr;
      mem_data = data;
      @(negedge clk);
      mem_we = 1'b0;
   endtask

   // Called at a negedge with reset high; returns at the negedge of run cycle 0.
   task automatic release_and_check(input string tag);
      int highs;
      highs = 0;
      reset = 1'b0;
      while (core_rst === 1'b1 && highs < 30) begin
         highs++;
         @(negedge clk);
      end
      n_tests++;
      if (highs != 10) begin
         n_fail++;
         $display("FAIL %s_hold_len: core_rst high for %0d samples, want 10", tag, highs);
      end
      n_tests++;
      if (st() !== 7'b0100000 || cycle_cnt !== 23'd0) begin
         n_fail++;
         $display("FAIL %s_run_start: status %b cnt %0d, want 0100000 cnt 0", tag, st(), cycle_cnt);
      end
   endtask

   task automatic start_run(input string tag);
      reset  = 1'b1;
      mem_we = 1'b0;
      pc     = '0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({st(), cycle_cnt, mailbox} !== {7'b1000000, 23'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL %s_reset_state: status %b cnt %0d mbox %h, want 1000000 cnt 0 mbox 0",
                  tag, st(), cycle_cnt, mailbox);
      end
      release_and_check(tag);
   endtask

   task automatic test_reset;
      start_run("reset");
   endtask

   task automatic test_pass;
      start_run("pass");
      for (int c = 0; c < 20; c++) run_cycle(pc_of(c), 1'b0, '0, '0);
      n_tests++;
      if (running !== 1'b1 || cycle_cnt !== 23'd20) begin
         n_fail++;
         $display("FAIL pass_pre: running %b cnt %0d, want 1 cnt 20", running, cycle_cnt);
      end
      run_cycle(pc_of(20), 1'b1, 32'h0000_1000, 32'h0000_600D);
      n_tests++;
      if ({st(), cycle_cnt, mailbox} !== {7'b1011000, 23'd20, 32'h0000_600D}) begin
         n_fail++;
         $display("FAIL pass_end: status %b cnt %0d mbox %h, want 1011000 cnt 20 mbox 0000600d",
                  st(), cycle_cnt, mailbox);
      end
   endtask

   task automatic test_fail_priority;
      start_run("fail");
      for (int c = 0; c < 49; c++) begin
         if (c == 10) begin
            run_cycle(pc_of(c), 1'b1, 32'h0000_1004, 32'h0000_0BAD);
            n_tests++;
            if ({st(), cycle_cnt, mailbox} !== {7'b0100000, 23'd11, 32'd0}) begin
               n_fail++;
               $display("FAIL fail_wrong_addr: status %b cnt %0d mbox %h, want 0100000 cnt 11 mbox 0",
                        st(), cycle_cnt, mailbox);
            end
         end else begin
            run_cycle(pc_of(c), 1'b0, '0, '0);
         end
      end
      run_cycle(pc_of(49), 1'b1, 32'h0000_1000, 32'h0000_0BAD);
      n_tests++;
      if ({st(), cycle_cnt, mailbox} !== {7'b1010100, 23'd49, 32'h0000_0BAD}) begin
         n_fail++;
         $display("FAIL fail_vs_timeout: status %b cnt %0d mbox %h, want 1010100 cnt 49 mbox 00000bad",
                  st(), cycle_cnt, mailbox);
      end
   endtask

   task automatic test_halt;
      int done_at;
      done_at = -1;
      start_run("halt");
      for (int c = 0; c < 60; c++) begin
         run_cycle((c < 30) ? pc_of(c) : 32'h0000_0040, 1'b0, '0, '0);
         if (done === 1'b1 && done_at < 0) done_at = c;
      end
      n_tests++;
      if (done_at != 37) begin
         n_fail++;
         $display("FAIL halt_cycle: run ended after cycle %0d, want 37", done_at);
      end
      n_tests++;
      if ({st(), cycle_cnt, mailbox} !== {7'b1010010, 23'd37, 32'd0}) begin
         n_fail++;
         $display("FAIL halt_end: status %b cnt %0d mbox %h, want 1010010 cnt 37 mbox 0",
                  st(), cycle_cnt, mailbox);
      end
      n_tests++;
      if ({ns_st(), ns_cycle_cnt} !== {7'b1010001, 23'd49}) begin
         n_fail++;
         $display("FAIL halt_disabled: status %b cnt %0d, want 1010001 cnt 49", ns_st(), ns_cycle_cnt);
      end
   endtask

   task automatic test_timeout;
      start_run("timeout");
      for (int c = 0; c < 49; c++) run_cycle(pc_of(c), 1'b0, '0, '0);
      n_tests++;
      if (st() !== 7'b0100000 || cycle_cnt !== 23'd49) begin
         n_fail++;
         $display("FAIL timeout_pre: status %b cnt %0d, want 0100000 cnt 49", st(), cycle_cnt);
      end
      run_cycle(pc_of(49), 1'b0, '0, '0);
      n_tests++;
      if ({st(), cycle_cnt} !== {7'b1010001, 23'd49}) begin
         n_fail++;
         $display("FAIL timeout_end: status %b cnt %0d, want 1010001 cnt 49", st(), cycle_cnt);
      end
      // Mailbox writes and a stuck PC in DONE must change nothing.
      for (int k = 0; k < 20; k++) begin
         run_cycle(32'h0000_0040, 1'b1, 32'h0000_1000, 32'h0000_600D);
         n_tests++;
         if ({st(), cycle_cnt, mailbox} !== {7'b1010001, 23'd49, 32'd0}) begin
            n_fail++;
            $display("FAIL timeout_hold_%0d: status %b cnt %0d mbox %h, want 1010001 cnt 49 mbox 0",
                     k, st(), cycle_cnt, mailbox);
         end
      end
   endtask

   task automatic test_mid_run_reset;
      start_run("midrst");
      for (int c = 0; c < 15; c++) run_cycle(pc_of(c), 1'b0, '0, '0);
      reset = 1'b1;
      run_cycle(pc_of(15), 1'b0, '0, '0);
      n_tests++;
      if ({st(), cycle_cnt, mailbox} !== {7'b1000000, 23'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL midrst_state: status %b cnt %0d mbox %h, want 1000000 cnt 0 mbox 0",
                  st(), cycle_cnt, mailbox);
      end
      release_and_check("midrst_again");
      for (int c = 0; c < 20; c++) run_cycle(pc_of(c), 1'b0, '0, '0);
      run_cycle(pc_of(20), 1'b1, 32'h0000_1000, 32'h0000_600D);
      n_tests++;
      if ({st(), cycle_cnt, mailbox} !== {7'b1011000, 23'd20, 32'h0000_600D}) begin
         n_fail++;
         $display("FAIL midrst_rerun: status %b cnt %0d mbox %h, want 1011000 cnt 20 mbox 0000600d",
                  st(), cycle_cnt, mailbox);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timer: simulation did not complete, %0d tests run", n_tests);
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_pass();
      test_fail_priority();
      test_halt();
      test_timeout();
      test_mid_run_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
